// File: rtl/quad_enc_pkg.sv
// Shared types and helpers for the quadrature encoder capture block:
// step classification, Gray-code decode and counter width helpers.
package quad_enc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_t;

  // Sized for the largest supported FILTER_DEPTH (255).
  localparam int FILT_CNT_W = $clog2(256);
  localparam int ARM_CNT_W  = $clog2(256 + 3);

  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Forward Gray order on {A,B}: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    if (prev == cur) begin
      s = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = STEP_ILLEGAL;
    end else begin
      case (prev)
        2'b00:   s = (cur == 2'b01) ? STEP_FWD : STEP_REV;
        2'b01:   s = (cur == 2'b11) ? STEP_FWD : STEP_REV;
        2'b11:   s = (cur == 2'b10) ? STEP_FWD : STEP_REV;
        default: s = (cur == 2'b00) ? STEP_FWD : STEP_REV;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Two-flop synchroniser followed by an inertial filter: the output follows
// the input only after FILTER_DEPTH consecutive differing samples.
module enc_input_filter
  import quad_enc_pkg::*;
#(
  parameter int FILTER_DEPTH = 8
) (
  input  logic clk,
  input  logic synch_reset,
  input  logic raw,
  output logic filtered
);

  logic                  sync1;
  logic                  sync2;
  logic [FILT_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filtered) begin
        cnt <= '0;
      end else if (cnt == FILT_CNT_W'(FILTER_DEPTH - 1)) begin
        filtered <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_capture.sv
// Multi-channel quadrature encoder front end: filtered inputs, wrapping
// position, microsecond step timestamps/periods and beam-edge capture.
module quad_encoder_capture
  import quad_enc_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int FILTER_DEPTH = 8,
  parameter int POS_WIDTH    = 16,
  parameter int TS_WIDTH     = 32,
  parameter int TICK_DIV     = 50,
  parameter int ZERO_ON_BEAM = 1
) (
  input  logic                          clk,
  input  logic                          synch_reset,
  input  logic [CHANNELS-1:0]           enc_a,
  input  logic [CHANNELS-1:0]           enc_b,
  input  logic [CHANNELS-1:0]           beam,
  input  logic [CHANNELS-1:0]           clear,
  input  logic [CHANNELS-1:0]           irq_ack,
  output logic [CHANNELS*POS_WIDTH-1:0] position,
  output logic [CHANNELS*TS_WIDTH-1:0]  step_ts,
  output logic [CHANNELS*TS_WIDTH-1:0]  period,
  output logic [CHANNELS*TS_WIDTH-1:0]  beam_ts,
  output logic [CHANNELS*POS_WIDTH-1:0] beam_pos,
  output logic [CHANNELS-1:0]           dir,
  output logic [CHANNELS-1:0]           err,
  output logic [CHANNELS-1:0]           irq,
  output logic [TS_WIDTH-1:0]           us_count
);

  localparam int PRESC_W = presc_width(TICK_DIV);

  logic [PRESC_W-1:0]   presc;
  logic [ARM_CNT_W-1:0] arm_cnt;
  logic                 armed;
  logic [CHANNELS-1:0]  a_f;
  logic [CHANNELS-1:0]  b_f;
  logic [CHANNELS-1:0]  beam_f;

  always_ff @(posedge clk) begin
    if (synch_reset) begin
      presc    <= '0;
      us_count <= '0;
    end else if (presc == PRESC_W'(TICK_DIV - 1)) begin
      presc    <= '0;
      us_count <= us_count + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Hold off decoding until the filters have had time to settle after reset.
  always_ff @(posedge clk) begin
    if (synch_reset) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
      armed   <= (arm_cnt == ARM_CNT_W'(FILTER_DEPTH + 2));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]           prev_ab;
    logic                 beam_prev;
    logic                 have_step;
    logic [1:0]           cur_ab;
    step_t                step;
    logic                 step_ok;
    logic                 step_fwd;
    logic                 beam_rise;
    logic [POS_WIDTH-1:0] delta;
    logic [POS_WIDTH-1:0] pos_base;
    logic [POS_WIDTH-1:0] pos_q;
    logic [POS_WIDTH-1:0] beam_pos_q;
    logic [TS_WIDTH-1:0]  step_ts_q;
    logic [TS_WIDTH-1:0]  period_q;
    logic [TS_WIDTH-1:0]  beam_ts_q;
    logic                 dir_q;
    logic                 err_q;
    logic                 irq_q;

    enc_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_a (
      .clk(clk), .synch_reset(synch_reset), .raw(enc_a[i]), .filtered(a_f[i]));
    enc_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_b (
      .clk(clk), .synch_reset(synch_reset), .raw(enc_b[i]), .filtered(b_f[i]));
    enc_input_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_filt_beam (
      .clk(clk), .synch_reset(synch_reset), .raw(beam[i]), .filtered(beam_f[i]));

    assign cur_ab    = {a_f[i], b_f[i]};
    assign step      = decode_step(prev_ab, cur_ab);
    assign step_fwd  = (step == STEP_FWD);
    assign step_ok   = (step == STEP_FWD) || (step == STEP_REV);
    assign beam_rise = beam_f[i] & ~beam_prev;
    assign delta     = step_fwd ? POS_WIDTH'(1) : ((step == STEP_REV) ? '1 : '0);
    assign pos_base  = ((ZERO_ON_BEAM != 0) && beam_rise) ? '0 : pos_q;

    always_ff @(posedge clk) begin
      if (synch_reset) begin
        prev_ab    <= '0;
        beam_prev  <= 1'b0;
        have_step  <= 1'b0;
        pos_q      <= '0;
        beam_pos_q <= '0;
        step_ts_q  <= '0;
        period_q   <= '0;
        beam_ts_q  <= '0;
        dir_q      <= 1'b0;
        err_q      <= 1'b0;
        irq_q      <= 1'b0;
      end else begin
        prev_ab   <= cur_ab;
        beam_prev <= beam_f[i];
        if (armed) begin
          if (beam_rise) begin
            beam_pos_q <= pos_q;
            beam_ts_q  <= us_count;
          end
          if ((step == STEP_ILLEGAL) || beam_rise) begin
            irq_q <= 1'b1;
          end else if (irq_ack[i]) begin
            irq_q <= 1'b0;
          end
          if (clear[i]) begin
            pos_q     <= '0;
            period_q  <= '0;
            err_q     <= 1'b0;
            have_step <= 1'b0;
          end else begin
            if (step == STEP_ILLEGAL) err_q <= 1'b1;
            pos_q <= pos_base + delta;
            if (step_ok) begin
              step_ts_q <= us_count;
              // A direction change restarts period measurement.
              period_q  <= (have_step && (step_fwd == dir_q)) ? (us_count - step_ts_q) : '0;
              dir_q     <= step_fwd;
              have_step <= 1'b1;
            end
          end
        end
      end
    end

    assign position[i*POS_WIDTH +: POS_WIDTH] = pos_q;
    assign beam_pos[i*POS_WIDTH +: POS_WIDTH] = beam_pos_q;
    assign step_ts[i*TS_WIDTH +: TS_WIDTH]    = step_ts_q;
    assign period[i*TS_WIDTH +: TS_WIDTH]     = period_q;
    assign beam_ts[i*TS_WIDTH +: TS_WIDTH]    = beam_ts_q;
    assign dir[i] = dir_q;
    assign err[i] = err_q;
    assign irq[i] = irq_q;
  end

endmodule
